// File: rtl/adc_channel_averager.sv
// Snapshots NUM_CH parallel ADC channels once per divider period and
// publishes a boxcar average of 2^AVG_LOG2 snapshots per channel.
module adc_channel_averager #(
  parameter int NUM_CH     = 13,
  parameter int DATA_W     = 12,
  parameter int AVG_LOG2   = 3,
  parameter int SAMPLE_DIV = 6100
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH*DATA_W-1:0] ch_flat,
  input  logic [DATA_W-1:0]        thr_high,
  output logic [NUM_CH*DATA_W-1:0] avg_flat,
  output logic                     avg_valid,
  output logic [NUM_CH-1:0]        over_thr,
  output logic                     busy
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int SNP_W = AVG_LOG2 + 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_CH - 1);
  localparam logic [SNP_W-1:0] SNP_MAX = SNP_W'(1 << AVG_LOG2);

  if (SAMPLE_DIV < NUM_CH + 2) begin : g_bad_div
    $error("SAMPLE_DIV must be at least NUM_CH+2");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DUMP
  } state_t;

  state_t                     state_q, state_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic                       tick_q, tick_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [SNP_W-1:0]           snp_q, snp_d;
  logic [ACC_W-1:0]           acc_q [NUM_CH];
  logic [ACC_W-1:0]           acc_d [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]   avg_q, avg_d;
  logic [NUM_CH-1:0]          over_q, over_d;
  logic                       valid_q, valid_d;
  logic [DATA_W-1:0]          ch_sel;
  logic [SNP_W-1:0]           snp_inc;

  assign ch_sel  = ch_flat[int'(idx_q)*DATA_W +: DATA_W];
  assign snp_inc = snp_q + 1'b1;

  always_comb begin
    div_d   = div_q;
    tick_d  = 1'b0;
    state_d = state_q;
    idx_d   = idx_q;
    snp_d   = snp_q;
    acc_d   = acc_q;
    avg_d   = avg_q;
    over_d  = over_q;
    valid_d = 1'b0;

    if (!enable) begin
      div_d = '0;
    end else if (div_q == DIV_MAX) begin
      div_d  = '0;
      tick_d = 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (tick_q) begin
          state_d = SCAN;
          idx_d   = '0;
        end else if (!enable) begin
          snp_d = '0;
          for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
        end
      end
      SCAN: begin
        acc_d[idx_q] = acc_q[idx_q] + ACC_W'(ch_sel);
        idx_d        = idx_q + 1'b1;
        if (idx_q == IDX_MAX) begin
          snp_d   = snp_inc;
          state_d = (snp_inc == SNP_MAX) ? DUMP : IDLE;
        end
      end
      DUMP: begin
        // Truncating divide: the average is the top DATA_W bits of the sum
        for (int i = 0; i < NUM_CH; i++) begin
          avg_d[i*DATA_W +: DATA_W] = acc_q[i][AVG_LOG2 +: DATA_W];
          over_d[i] = acc_q[i][AVG_LOG2 +: DATA_W] > thr_high;
          acc_d[i]  = '0;
        end
        snp_d   = '0;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      tick_q  <= 1'b0;
      idx_q   <= '0;
      snp_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      avg_q   <= '0;
      over_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      snp_q   <= snp_d;
      acc_q   <= acc_d;
      avg_q   <= avg_d;
      over_q  <= over_d;
      valid_q <= valid_d;
    end
  end

  assign avg_flat  = avg_q;
  assign over_thr  = over_q;
  assign avg_valid = valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adc_channel_averager.sv
// Scoreboard bench for adc_channel_averager: expected averages are
// queued when a pass is driven and compared on each avg_valid.
module tb_adc_channel_averager;

  localparam int NCH = 13;
  localparam int DW  = 12;
  localparam int DIV = 32;
  localparam int W   = NCH * DW;

  typedef struct packed {
    logic [W-1:0]   avg;
    logic [NCH-1:0] over;
  } exp_t;

  logic           clock = 1'b0;
  logic           rst;
  logic           enable;
  logic [W-1:0]   ch_flat;
  logic [DW-1:0]  thr_high;
  logic [W-1:0]   avg_flat;
  logic           avg_valid;
  logic [NCH-1:0] over_thr;
  logic           busy;

  exp_t sb [$];
  exp_t e_mon;
  exp_t last_exp;
  int   n_chk;
  int   n_pass;
  int   n_valid;
  int   snaps [8][NCH];

  adc_channel_averager #(
    .NUM_CH    (NCH),
    .DATA_W    (DW),
    .AVG_LOG2  (3),
    .SAMPLE_DIV(DIV)
  ) dut (
    .clock    (clock),
    .rst      (rst),
    .enable   (enable),
    .ch_flat  (ch_flat),
    .thr_high (thr_high),
    .avg_flat (avg_flat),
    .avg_valid(avg_valid),
    .over_thr (over_thr),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clock) begin
    if (avg_valid === 1'b1) begin
      n_valid++;
      check("valid_expected", W'(sb.size() > 0), W'(1));
      if (sb.size() > 0) begin
        e_mon = sb.pop_front();
        check("avg_flat", avg_flat, e_mon.avg);
        check("over_thr", W'(over_thr), W'(e_mon.over));
      end
    end
  end

  function automatic exp_t model(input logic [DW-1:0] thr);
    exp_t m;
    m = '0;
    for (int i = 0; i < NCH; i++) begin
      int s;
      int a;
      s = 0;
      for (int k = 0; k < 8; k++) s += snaps[k][i];
      a = s / 8;
      m.avg[i*DW +: DW] = DW'(a);
      m.over[i] = (a > int'(thr));
    end
    return m;
  endfunction

  task automatic drive(input int k);
    for (int i = 0; i < NCH; i++)
      ch_flat[i*DW +: DW] = DW'(snaps[k][i]);
  endtask

  task automatic wait_busy(output bit ok);
    int t;
    t = 0;
    while (busy !== 1'b1 && t < DIV * 3) begin
      @(negedge clock);
      t++;
    end
    ok = (busy === 1'b1);
    if (!ok) check("tick_seen", W'(busy), W'(1));
  endtask

  task automatic do_snap(input int k, output int bcyc);
    bit ok;
    drive(k);
    bcyc = 0;
    wait_busy(ok);
    if (ok) begin
      while (busy === 1'b1 && bcyc < 40) begin
        @(negedge clock);
        bcyc++;
      end
    end
  endtask

  task automatic run_pass(input logic [DW-1:0] thr);
    int b;
    thr_high = thr;
    last_exp = model(thr);
    sb.push_back(last_exp);
    for (int k = 0; k < 8; k++) begin
      do_snap(k, b);
      check("busy_cycles", W'(b), W'((k == 7) ? 14 : 13));
      check("valid_at_k", W'(avg_valid), W'(k == 7));
    end
    @(negedge clock);
    check("valid_width", W'(avg_valid), W'(0));
    check("avg_hold", avg_flat, last_exp.avg);
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < NCH; i++) snaps[k][i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int bz;
    bit ok;
    n_chk = 0; n_pass = 0; n_valid = 0;
    rst = 1'b1; enable = 1'b0; ch_flat = '0; thr_high = '0;
    repeat (3) @(negedge clock);
    check("rst_avg", avg_flat, '0);
    check("rst_over", W'(over_thr), '0);
    check("rst_valid", W'(avg_valid), '0);
    check("rst_busy", W'(busy), '0);
    rst = 1'b0;
    enable = 1'b1;

    for (int k = 0; k < 8; k++)
      for (int i = 0; i < NCH; i++) snaps[k][i] = 100 * i;
    run_pass(12'hfff);

    for (int k = 0; k < 8; k++)
      for (int i = 0; i < NCH; i++) snaps[k][i] = (i == 3) ? k : 0;
    run_pass(12'd2);

    fill_const(4095);
    run_pass(12'd4094);
    fill_const(0);
    run_pass(12'd0);

    fill_const(2000);
    for (int k = 0; k < 8; k++) snaps[k][5] = 2001;
    run_pass(12'd2000);
    run_pass(12'd2001);

    fill_const(3000);
    for (int k = 0; k < 7; k++) do_snap(k, b);
    drive(7);
    wait_busy(ok);
    repeat (5) @(negedge clock);
    rst = 1'b1;
    #1;
    check("mid_rst_avg", avg_flat, '0);
    check("mid_rst_over", W'(over_thr), '0);
    check("mid_rst_valid", W'(avg_valid), '0);
    check("mid_rst_busy", W'(busy), '0);
    repeat (2) @(negedge clock);
    rst = 1'b0;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < NCH; i++) snaps[k][i] = i * 7 + k * 11;
    run_pass(12'd60);

    fill_const(3000);
    for (int k = 0; k < 4; k++) do_snap(k, b);
    enable = 1'b0;
    bz = 0;
    repeat (100) begin
      @(negedge clock);
      if (busy === 1'b1) bz++;
    end
    check("disabled_busy", W'(bz), '0);
    check("disabled_avg", avg_flat, last_exp.avg);
    enable = 1'b1;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < NCH; i++) snaps[k][i] = 50 + i * 3 + k;
    run_pass(12'd60);

    repeat (3) @(posedge clock);
    check("sb_empty", W'(sb.size()), '0);
    check("valid_count", W'(n_valid), W'(8));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_channel_averager.md
Name: adc_channel_averager

Overview:
- Downstream consumer of the 13-channel ADC interface's parallel 12-bit channel registers.
- Snapshots all channels once per conversion period and boxcar-averages 2^AVG_LOG2 snapshots per channel.
- Publishes one averaged value per channel with a single-cycle valid pulse, plus per-channel over-threshold flags for the processor-side logic.

Parameters:
- NUM_CH, 13: number of channels.
- DATA_W, 12: sample width.
- AVG_LOG2, 3: log2 of the number of snapshots averaged (8).
- SAMPLE_DIV, 6100: clocks between snapshots. Must be >= NUM_CH+2; enforce with an elaboration-time check.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run control; level-sensitive.
- ch_flat  in  NUM_CH*DATA_W  channel values; CH0 in bits [DATA_W-1:0], CHi in [(i+1)*DATA_W-1 : i*DATA_W].
- thr_high  in  DATA_W  unsigned alarm threshold.
- avg_flat  out  NUM_CH*DATA_W  averaged values; same packing as ch_flat.
- avg_valid  out  1  one-cycle pulse; avg_flat and over_thr are updated on the same edge.
- over_thr  out  NUM_CH  bit i = 1 when average i > thr_high (strictly greater).
- busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset (async, immediate): avg_flat=0, over_thr=0, avg_valid=0, busy=0. Divider, snapshot counter and all accumulators go to 0. FSM goes to IDLE.
- Divider:
  - Counts 0..SAMPLE_DIV-1 while enable=1 and wraps.
  - tick is a registered 1-cycle pulse, high in the cycle after the count reaches SAMPLE_DIV-1.
  - enable=0 holds the divider at 0; no tick is produced.
- Accumulators: NUM_CH registers of width DATA_W+AVG_LOG2 (15 bits). No overflow is possible: max sum 8*4095 = 32760.
- FSM states IDLE, SCAN, DUMP:
  - IDLE:
    - tick -> SCAN with idx=0.
    - If enable=0 in IDLE: clear the snapshot counter and all accumulators; avg_flat and over_thr are retained.
  - SCAN, one channel per cycle:
    - acc[idx] <= acc[idx] + CH[idx], reading ch_flat live in that cycle.
    - idx increments. After idx=NUM_CH-1, the snapshot counter increments.
    - Counter reached 2^AVG_LOG2 -> DUMP. Otherwise -> IDLE.
    - Scan takes NUM_CH cycles. Channels are sampled in different cycles; this skew is accepted.
  - DUMP, 1 cycle:
    - avg[i] <= acc[i] >> AVG_LOG2 (truncate, no rounding).
    - over_thr[i] <= (acc[i] >> AVG_LOG2) > thr_high, using thr_high as sampled in this cycle.
    - All acc cleared, snapshot counter cleared, avg_valid=1 for this one cycle.
    - -> IDLE.
- Latency: a tick in cycle T starts SCAN at T+1. For the final snapshot, DUMP is at T+NUM_CH+1, and avg_flat, over_thr and avg_valid are visible from T+NUM_CH+2. First valid comes 8 snapshot periods after enable rises.
- busy=1 in SCAN and DUMP.
- Simultaneous events:
  - A tick cannot occur in SCAN/DUMP given the SAMPLE_DIV constraint.
  - enable falling mid-SCAN/DUMP: the current pass completes, including DUMP if due. The clear then happens in IDLE.
  - thr_high changing mid-cycle: only the value in the DUMP cycle matters.
- Reset mid-SCAN/DUMP: immediate return to reset state. Partial sums are discarded and avg_valid is not emitted.
- Outputs other than avg_valid hold their values between DUMPs.

Test Plan:
- Reset then constant inputs CHi=100*i, SAMPLE_DIV=32, enable=1 -> first avg_valid after 8 ticks, exactly 1 cycle wide; avg i = 100*i; busy high for 14 cycles on the 8th tick (13 SCAN + 1 DUMP).
- CH3 takes values 0,1,...,7 on successive snapshots, others 0 -> avg3 = 28>>3 = 3 (truncation); other averages 0.
- All channels 4095 for 8 snapshots -> all averages 4095, no wrap. A following pass with all 0 -> all averages 0; accumulators confirmed cleared.
- thr_high=2000, CH5=2001, all others 2000 -> over_thr=13'h0020. Change thr_high to 2001 before the next DUMP -> over_thr=0.
- Assert rst during SCAN of the 8th snapshot -> outputs 0 immediately, no avg_valid; after release, the next valid requires 8 fresh ticks.
- enable low for 100 cycles after 4 snapshots -> no ticks; snapshot counter and accumulators cleared; avg_flat unchanged. On re-enable, 8 new ticks are needed before the next valid.
